// File: rtl/tlb_array.sv
// Joint TLB storage with two search ports, indexed read/write, probe, and the CP0 Random counter.
// Every result is registered with 1-cycle latency; there is no stall path, so each port accepts a new request every cycle.
package tlb_array_pkg;
    typedef struct packed {
        logic [18:0] vpn2;
        logic [7:0]  asid;
        logic        g;
        logic [19:0] pfn0;
        logic [2:0]  c0;
        logic        d0;
        logic        v0;
        logic [19:0] pfn1;
        logic [2:0]  c1;
        logic        d1;
        logic        v1;
    } tlb_entry_t;
endpackage

module tlb_array
    import tlb_array_pkg::*;
#(
    parameter int TLBNUM = 16,
    parameter int IDXW   = $clog2(TLBNUM)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [7:0]      cp0_asid,
    input  logic [18:0]     s0_vpn2,
    output tlb_entry_t      s0_entry,
    output logic            s0_found,
    input  logic [18:0]     s1_vpn2,
    output tlb_entry_t      s1_entry,
    output logic            s1_found,
    input  logic            we,
    input  logic [IDXW-1:0] w_index,
    input  tlb_entry_t      w_entry,
    input  logic [IDXW-1:0] r_index,
    output tlb_entry_t      r_entry,
    input  logic            p_req,
    input  logic [18:0]     p_vpn2,
    output logic            p_done,
    output logic            p_found,
    output logic [IDXW-1:0] p_index,
    input  logic [IDXW-1:0] wired,
    input  logic            wired_wr,
    output logic [IDXW-1:0] random_index
);

    localparam logic [IDXW-1:0] MAX_IDX = IDXW'(TLBNUM - 1);

    tlb_entry_t        ent [TLBNUM];
    logic [TLBNUM-1:0] wv;

    logic            s0_hit, s1_hit, p_hit;
    logic [IDXW-1:0] s0_idx, s1_idx, p_idx;

    // V bits are deliberately ignored: validity checking belongs to the TLB buffers.
    function automatic logic match(input tlb_entry_t e, input logic valid,
                                   input logic [18:0] vpn2, input logic [7:0] asid);
        return valid && (e.vpn2 == vpn2) && (e.g || (e.asid == asid));
    endfunction

    // Scan high-to-low so the lowest matching index is the one left standing.
    always_comb begin
        s0_hit = 1'b0;
        s0_idx = '0;
        s1_hit = 1'b0;
        s1_idx = '0;
        p_hit  = 1'b0;
        p_idx  = '0;
        for (int i = TLBNUM - 1; i >= 0; i--) begin
            if (match(ent[i], wv[i], s0_vpn2, cp0_asid)) begin
                s0_hit = 1'b1;
                s0_idx = IDXW'(i);
            end
            if (match(ent[i], wv[i], s1_vpn2, cp0_asid)) begin
                s1_hit = 1'b1;
                s1_idx = IDXW'(i);
            end
            if (match(ent[i], wv[i], p_vpn2, cp0_asid)) begin
                p_hit = 1'b1;
                p_idx = IDXW'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < TLBNUM; i++) begin
                ent[i] <= '0;
            end
            wv <= '0;
        end else if (we) begin
            ent[w_index] <= w_entry;
            wv[w_index]  <= 1'b1;
        end
    end

    // All lookups read the array before this edge's write lands.
    always_ff @(posedge clk) begin
        if (rst) begin
            s0_entry <= '0;
            s0_found <= 1'b0;
            s1_entry <= '0;
            s1_found <= 1'b0;
            r_entry  <= '0;
            p_done   <= 1'b0;
            p_found  <= 1'b0;
            p_index  <= '0;
        end else begin
            s0_found <= s0_hit;
            s0_entry <= s0_hit ? ent[s0_idx] : '0;
            s1_found <= s1_hit;
            s1_entry <= s1_hit ? ent[s1_idx] : '0;
            r_entry  <= wv[r_index] ? ent[r_index] : '0;
            p_done   <= p_req;
            if (p_req) begin
                p_found <= p_hit;
                p_index <= p_hit ? p_idx : '0;
            end
        end
    end

    // Wrapping at or below wired also pins the counter at the top when wired >= TLBNUM-1.
    always_ff @(posedge clk) begin
        if (rst) begin
            random_index <= MAX_IDX;
        end else if (wired_wr || (random_index <= wired)) begin
            random_index <= MAX_IDX;
        end else begin
            random_index <= random_index - 1'b1;
        end
    end

endmodule
